// File: rtl/sseg_pkg.sv
// Shared constants, scan-state enum and anode helper for the seven-segment scan controller.
package sseg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    // One-hot-low anode strobe for the given digit index.
    function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
        logic [3:0] an;
        an      = AN_OFF;
        an[idx] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational nibble to active-low gfedcba decoder; codes 10-15 render as a dark digit.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// 4-digit common-anode scan controller with double-buffered value and leading-zero blanking.
// Optional SSEG_DIM_EN adds a brightness[3:0] input that shortens the anode on-time per slot.
//
// state | meaning
// IDLE  | display dark, index/prescaler held at 0, shadow tracks pending
// SCAN  | rotating anodes, shadow refreshed only at frame boundary
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
`ifdef SSEG_DIM_EN
    input  logic [3:0]  brightness,
`endif
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] PRESC_TC  = CNT_W'(TICK_DIV - 1);
    localparam logic [1:0]       LAST_IDX  = 2'(NUM_DIGITS - 1);

    scan_state_e      state_q;
    logic [CNT_W-1:0] presc_q;
    logic [1:0]       idx_q;
    logic [15:0]      pend_val_q;
    logic [3:0]       pend_dp_q;
    logic [15:0]      shadow_val_q;
    logic [3:0]       shadow_dp_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dpn_q;
    logic             frame_done_q;

    logic [3:0]       nib_sel;
    logic [6:0]       dec_seg;
    logic [3:0]       zero_run;
    logic             lz_hit;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dpn_d;

`ifdef SSEG_DIM_EN
    localparam int LIM_W = CNT_W + 5;
    logic [3:0]       bright_q;
    logic [LIM_W-1:0] on_lim;
`endif

    hex_to_sseg u_dec (
        .hex_i (nib_sel),
        .seg_o (dec_seg)
    );

    always_comb begin
        nib_sel     = shadow_val_q[{idx_q, 2'b00} +: 4];

        // zero_run[k]: nibble k and every nibble above it are zero
        zero_run[3] = (shadow_val_q[15:12] == 4'd0);
        zero_run[2] = (shadow_val_q[11:8]  == 4'd0) && zero_run[3];
        zero_run[1] = (shadow_val_q[7:4]   == 4'd0) && zero_run[2];
        zero_run[0] = (shadow_val_q[3:0]   == 4'd0) && zero_run[1];
        lz_hit      = lz_blank && (idx_q != 2'd0) && zero_run[idx_q];

        seg_d       = lz_hit ? SEG_BLANK : dec_seg;
        dpn_d       = ~shadow_dp_q[idx_q];

`ifdef SSEG_DIM_EN
        on_lim = ((LIM_W'(bright_q) + LIM_W'(1)) * LIM_W'(TICK_DIV)) >> 4;
        an_d   = (LIM_W'(presc_q) < on_lim) ? an_onehot_low(idx_q) : AN_OFF;
`else
        an_d   = an_onehot_low(idx_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dpn_q        <= 1'b1;
            frame_done_q <= 1'b0;
`ifdef SSEG_DIM_EN
            bright_q     <= '0;
`endif
        end else begin
            frame_done_q <= 1'b0;

            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
            end

            case (state_q)
                IDLE: begin
                    an_q         <= AN_OFF;
                    seg_q        <= SEG_BLANK;
                    dpn_q        <= 1'b1;
                    presc_q      <= '0;
                    idx_q        <= '0;
                    shadow_val_q <= pend_val_q;
                    shadow_dp_q  <= pend_dp_q;
`ifdef SSEG_DIM_EN
                    bright_q     <= brightness;
`endif
                    if (enable) begin
                        state_q <= SCAN;
                    end
                end

                SCAN: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        an_q    <= AN_OFF;
                        seg_q   <= SEG_BLANK;
                        dpn_q   <= 1'b1;
                        presc_q <= '0;
                        idx_q   <= '0;
                    end else begin
                        // outputs follow the index one cycle late, all on the same edge
                        an_q  <= an_d;
                        seg_q <= seg_d;
                        dpn_q <= dpn_d;
                        if (presc_q == PRESC_TC) begin
                            presc_q <= '0;
                            idx_q   <= idx_q + 2'd1;
`ifdef SSEG_DIM_EN
                            bright_q <= brightness;
`endif
                            if (idx_q == LAST_IDX) begin
                                frame_done_q <= 1'b1;
                                shadow_val_q <= pend_val_q;
                                shadow_dp_q  <= pend_dp_q;
                            end
                        end else begin
                            presc_q <= presc_q + CNT_W'(1);
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_n       = dpn_q;
    assign frame_done = frame_done_q;

endmodule
